// File: rtl/playback_serializer.sv
// Playback serializer: fetches a clip word by word and shifts each word out
// MSB first. Each bit is held for CLK_DIV clocks, and the next word is
// prefetched so the stream has no gaps.
module playback_serializer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 17,
    parameter int CLIP_WORDS = 65536,
    parameter int CLK_DIV    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] startAddress,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              audio_out,
    output logic              audio_en,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (CLIP_WORDS > 1) ? $clog2(CLIP_WORDS) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLIP_WORDS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] SHIFT = 2'd3;

    logic [1:0]        state;
    logic              armed;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_vld;
    logic              pf_pend;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              bit_end;
    logic              word_end;

    // The word address wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [IDX_W-1:0]  i);
        return b + ADDR_W'(i);
    endfunction

    assign bit_end   = (div_cnt == LAST_DIV);
    assign word_end  = bit_end && (bit_cnt == LAST_BIT);
    assign busy      = (state != IDLE);
    assign audio_en  = (state == SHIFT);
    assign audio_out = (state == SHIFT) && shift_reg[DATA_W-1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            armed     <= 1'b1;
            base      <= '0;
            index     <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_vld  <= 1'b0;
            pf_pend   <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            done      <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            done    <= 1'b0;
            // Read data for a prefetch issued in SHIFT arrives one cycle later.
            pf_pend <= (state == SHIFT) && mem_en && enable;
            if (state != IDLE && !enable) begin
                state    <= IDLE;
                armed    <= 1'b1;
                hold_vld <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!enable) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            base     <= startAddress;
                            index    <= '0;
                            mem_en   <= 1'b1;
                            mem_addr <= startAddress;
                            state    <= FETCH;
                        end
                    end
                    FETCH: state <= WAIT;
                    WAIT: begin
                        shift_reg <= mem_dout;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        hold_vld  <= 1'b0;
                        state     <= SHIFT;
                        if (CLIP_WORDS > 1) begin
                            mem_en   <= 1'b1;
                            mem_addr <= word_addr(base, IDX_W'(1));
                        end
                    end
                    SHIFT: begin
                        if (pf_pend) begin
                            hold_reg <= mem_dout;
                            hold_vld <= 1'b1;
                        end
                        if (!bit_end) begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end else begin
                            div_cnt <= '0;
                            if (!word_end) begin
                                shift_reg <= shift_reg << 1;
                                bit_cnt   <= bit_cnt + BIT_W'(1);
                            end else if (index == LAST_IDX) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                armed <= 1'b0;
                            end else begin
                                // Next word starts immediately; prefetch the one after it.
                                shift_reg <= hold_vld ? hold_reg : '0;
                                hold_vld  <= 1'b0;
                                bit_cnt   <= '0;
                                index     <= index + IDX_W'(1);
                                if ((index + IDX_W'(1)) < LAST_IDX) begin
                                    mem_en   <= 1'b1;
                                    mem_addr <= word_addr(base, index + IDX_W'(2));
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playback_serializer.sv
// Directed bench for playback_serializer: 3-word clip (normal, re-arm, wrap,
// abort, mid-clip reset) and a 1-word clip, checked cycle by cycle.
module tb_playback_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [16:0] sa_a, sa_b;
    logic [3:0]  dout_a, dout_b;
    logic        me_a, me_b, ao_a, ao_b, ae_a, ae_b, bz_a, bz_b, dn_a, dn_b;
    logic [16:0] ad_a, ad_b;
    logic [3:0]  mem_a [0:131071];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    playback_serializer #(.DATA_W(4), .ADDR_W(17), .CLIP_WORDS(3), .CLK_DIV(4)) dut_a (
        .clock(clk), .reset(rst_n), .enable(en_a), .startAddress(sa_a),
        .mem_dout(dout_a), .mem_en(me_a), .mem_addr(ad_a), .audio_out(ao_a),
        .audio_en(ae_a), .busy(bz_a), .done(dn_a)
    );

    playback_serializer #(.DATA_W(4), .ADDR_W(17), .CLIP_WORDS(1), .CLK_DIV(4)) dut_b (
        .clock(clk), .reset(rst_n), .enable(en_b), .startAddress(sa_b),
        .mem_dout(dout_b), .mem_en(me_b), .mem_addr(ad_b), .audio_out(ao_b),
        .audio_en(ae_b), .busy(bz_b), .done(dn_b)
    );

    // Synchronous read memories: data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (me_a) dout_a <= mem_a[ad_a];
        if (me_b) dout_b <= (ad_b == 17'h00040) ? 4'h9 : 4'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs d cycles after enable rises (3-word clip, 4 cycles/bit).
    task automatic exp_a(input int d, input logic [16:0] sa, input logic [11:0] st,
                         output logic me, output logic [16:0] ad, output logic ae,
                         output logic ao, output logic bz, output logic dn);
        int bi;
        me = (d == 1) || (d == 3) || (d == 19);
        ad = (d == 1) ? sa : (d == 3) ? sa + 17'd1 : sa + 17'd2;
        ae = (d >= 3) && (d <= 50);
        bi = ae ? 11 - (d - 3) / 4 : 0;
        ao = ae ? st[bi] : 1'b0;
        bz = (d >= 1) && (d <= 50);
        dn = (d == 51);
    endtask

    task automatic run_a(input string name, input logic [16:0] sa, input logic [11:0] st,
                         input int abort_cyc, input int reset_cyc, input int ncyc,
                         input bit chg_sa);
        logic me, ae, ao, bz, dn;
        logic [16:0] ad;
        int d;
        sa_a = sa;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) en_a = 1'b1;
            if (c == abort_cyc) en_a = 1'b0;
            if (c == reset_cyc) rst_n = 1'b0;
            if (reset_cyc >= 0 && c == reset_cyc + 1) rst_n = 1'b1;
            if (chg_sa && c == 5) sa_a = 17'h0AAAA;
            @(negedge clk);
            d = (reset_cyc >= 0 && c > reset_cyc) ? c - reset_cyc - 1 : c;
            exp_a(d, sa, st, me, ad, ae, ao, bz, dn);
            if (abort_cyc >= 0 && c > abort_cyc) begin
                me = 1'b0; ae = 1'b0; ao = 1'b0; bz = 1'b0; dn = 1'b0;
            end
            check($sformatf("%s mem_en c%0d", name, c), 32'(me_a), 32'(me));
            if (me) check($sformatf("%s mem_addr c%0d", name, c), 32'(ad_a), 32'(ad));
            check($sformatf("%s audio_en c%0d", name, c), 32'(ae_a), 32'(ae));
            check($sformatf("%s audio_out c%0d", name, c), 32'(ao_a), 32'(ao));
            check($sformatf("%s busy c%0d", name, c), 32'(bz_a), 32'(bz));
            check($sformatf("%s done c%0d", name, c), 32'(dn_a), 32'(dn));
            @(posedge clk);
            #1;
        end
        sa_a = sa;
    endtask

    task automatic idle_cycle();
        en_a = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] st_b;
        int bi;
        st_b = 4'b1001;
        for (int i = 0; i < 131072; i++) mem_a[i] = 4'h0;
        mem_a[17'h00010] = 4'hA;
        mem_a[17'h00011] = 4'h5;
        mem_a[17'h00012] = 4'hF;
        mem_a[17'h1FFFF] = 4'hC;
        mem_a[17'h00000] = 4'h6;
        mem_a[17'h00001] = 4'h9;
        dout_a = 4'h0;
        dout_b = 4'h0;
        rst_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        sa_a = 17'h00010;
        sa_b = 17'h00040;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_en", 32'(me_a), 32'd0);
        check("reset mem_addr", 32'(ad_a), 32'd0);
        check("reset audio_out", 32'(ao_a), 32'd0);
        check("reset audio_en", 32'(ae_a), 32'd0);
        check("reset busy", 32'(bz_a), 32'd0);
        check("reset done", 32'(dn_a), 32'd0);
        check("reset b busy", 32'(bz_b), 32'd0);
        check("reset b mem_en", 32'(me_b), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_a("norm", 17'h00010, 12'hA5F, -1, -1, 60, 1'b1);

        // Enable stays high after done: no restart until it drops.
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check($sformatf("hold mem_en c%0d", c), 32'(me_a), 32'd0);
            check($sformatf("hold busy c%0d", c), 32'(bz_a), 32'd0);
            @(posedge clk);
            #1;
        end

        idle_cycle();
        run_a("rearm", 17'h00010, 12'hA5F, -1, -1, 56, 1'b0);
        idle_cycle();
        run_a("wrap", 17'h1FFFF, 12'hC69, -1, -1, 56, 1'b0);
        idle_cycle();
        run_a("abort", 17'h00010, 12'hA5F, 20, -1, 70, 1'b0);
        idle_cycle();
        run_a("reset", 17'h00010, 12'hA5F, -1, 25, 82, 1'b0);
        idle_cycle();

        // Single-word clip: one fetch, no prefetch, done 16 cycles after first bit.
        for (int c = 0; c < 26; c++) begin
            if (c == 0) en_b = 1'b1;
            @(negedge clk);
            check($sformatf("one mem_en c%0d", c), 32'(me_b), 32'(c == 1));
            if (c == 1) check("one mem_addr", 32'(ad_b), 32'h40);
            check($sformatf("one audio_en c%0d", c), 32'(ae_b), 32'(c >= 3 && c <= 18));
            bi = (c >= 3 && c <= 18) ? 3 - (c - 3) / 4 : 0;
            check($sformatf("one audio_out c%0d", c), 32'(ao_b),
                  32'((c >= 3 && c <= 18) ? st_b[bi] : 1'b0));
            check($sformatf("one busy c%0d", c), 32'(bz_b), 32'(c >= 1 && c <= 18));
            check($sformatf("one done c%0d", c), 32'(dn_b), 32'(c == 19));
            @(posedge clk);
            #1;
        end
        en_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
